// File: rtl/fm_radio_pkg.sv
// fm_radio_pkg: constants shared across the FM radio audio chain.
package fm_radio_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int QUANT_BITS = 10;
  localparam int PCM_WIDTH = 16;
  localparam int AUDIO_FIFO_DEPTH = 16;
  localparam logic [DATA_WIDTH-1:0] VOLUME_LEVEL = 32'h0000_0400;
  localparam logic [PCM_WIDTH-1:0] PCM_MAX = {1'b0, {(PCM_WIDTH-1){1'b1}}};
  localparam logic [PCM_WIDTH-1:0] PCM_MIN = {1'b1, {(PCM_WIDTH-1){1'b0}}};
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with count/empty/full; reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push, pop;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign count = count_q;
  assign rd_data = empty ? '0 : mem[rd_ptr_q];
  always_comb begin
    push = wr_en && !full;
    pop = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr_q] <= wr_data;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/audio_gain.sv
// audio_gain: fixed-gain multiply, dequantize and saturate IIR samples into a credit-throttled PCM FIFO.
module audio_gain #(
  parameter int DATA_WIDTH = fm_radio_pkg::DATA_WIDTH,
  parameter int OUT_WIDTH = fm_radio_pkg::PCM_WIDTH,
  parameter int QUANT_BITS = fm_radio_pkg::QUANT_BITS,
  parameter logic [DATA_WIDTH-1:0] GAIN = fm_radio_pkg::VOLUME_LEVEL,
  parameter int FIFO_DEPTH = fm_radio_pkg::AUDIO_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_empty,
  input  logic                  out_rd_en,
  output logic                  overflow,
  output logic                  saturated
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_WIDTH-1:0] s1_q, s1_d;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic overflow_q, overflow_d, saturated_q, saturated_d;
  logic signed [PW-1:0] prod_q, prod_d, q;
  logic [CW-1:0] fifo_count;
  logic [CW:0] pending;
  logic fifo_full, accept, clip_hi, clip_lo;
  logic [OUT_WIDTH-1:0] pcm;
  // In-flight samples reserve a FIFO slot so the unstallable pipeline can always land them.
  assign pending = {1'b0, fifo_count} + (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q);
  assign in_ready = pending < (CW+1)'(FIFO_DEPTH);
  assign overflow = overflow_q;
  assign saturated = saturated_q;
  always_comb begin
    accept = in_valid && in_ready;
    s1_d = accept ? in_data : s1_q;
    s1_v_d = accept;
    s2_v_d = s1_v_q;
    prod_d = {{DATA_WIDTH{s1_q[DATA_WIDTH-1]}}, s1_q} * {{DATA_WIDTH{GAIN[DATA_WIDTH-1]}}, GAIN};
    q = prod_q >>> QUANT_BITS;
    clip_hi = !q[PW-1] && (|q[PW-2:OUT_WIDTH-1]);
    clip_lo = q[PW-1] && !(&q[PW-2:OUT_WIDTH-1]);
    pcm = clip_hi ? OUT_WIDTH'(fm_radio_pkg::PCM_MAX) : clip_lo ? OUT_WIDTH'(fm_radio_pkg::PCM_MIN) : q[OUT_WIDTH-1:0];
    overflow_d = overflow_q || (in_valid && !in_ready);
    saturated_d = saturated_q || (s2_v_q && (clip_hi || clip_lo));
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1_q <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      prod_q <= '0;
      overflow_q <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      prod_q <= prod_d;
      overflow_q <= overflow_d;
      saturated_q <= saturated_d;
    end
  sync_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .wr_en(s2_v_q && !fifo_full),
    .wr_data(pcm),
    .rd_en(out_rd_en),
    .rd_data(out_data),
    .count(fifo_count),
    .empty(out_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_audio_gain.sv
// tb_audio_gain: directed scoreboard bench for audio_gain at unity and half gain.
module tb_audio_gain;
  logic clock = 0, reset = 0;
  logic [31:0] a_in_data = 0, b_in_data = 0;
  logic a_in_valid = 0, b_in_valid = 0, a_rd = 0, b_rd = 0;
  logic a_in_ready, a_empty, a_overflow, a_sat;
  logic b_in_ready, b_empty, b_overflow, b_sat;
  logic [15:0] a_out, b_out;
  logic [15:0] qa[$], qb[$];
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  audio_gain dut_a (
    .clock(clock), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out), .out_empty(a_empty), .out_rd_en(a_rd),
    .overflow(a_overflow), .saturated(a_sat)
  );

  audio_gain #(.GAIN(32'h0000_0200)) dut_b (
    .clock(clock), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out), .out_empty(b_empty), .out_rd_en(b_rd),
    .overflow(b_overflow), .saturated(b_sat)
  );

  function automatic logic [15:0] model(input int x, input int g);
    longint p;
    p = (longint'(x) * longint'(g)) >>> 10;
    return p > 32767 ? 16'h7fff : p < -32768 ? 16'h8000 : p[15:0];
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input int x);
    a_in_valid = 1;
    a_in_data = x;
    qa.push_back(model(x, 1024));
  endtask

  task automatic pop_a(input string tag);
    int n;
    n = 0;
    while (a_empty && n < 20) begin step; n++; end
    chk({tag, " avail"}, a_empty, 0);
    chk(tag, a_out, qa.size() > 0 ? qa.pop_front() : 16'hdead);
    a_rd = 1;
    step;
    a_rd = 0;
  endtask

  task automatic pop_b(input string tag);
    int n;
    n = 0;
    while (b_empty && n < 20) begin step; n++; end
    chk({tag, " avail"}, b_empty, 0);
    chk(tag, b_out, qb.size() > 0 ? qb.pop_front() : 16'hdead);
    b_rd = 1;
    step;
    b_rd = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " empty"}, a_empty, 1);
    chk({tag, " ready"}, a_in_ready, 1);
    chk({tag, " data"}, a_out, 0);
    chk({tag, " ovf"}, a_overflow, 0);
    chk({tag, " sat"}, a_sat, 0);
  endtask

  initial begin
    int acc;
    acc = 0;
    #2 reset = 1;
    #1;
    chk_reset("reset");
    chk("reset b empty", b_empty, 1);
    step;
    step;
    reset = 0;
    step;
    // unity gain: order and 3-edge latency
    send_a(1000);
    step;
    chk("lat e0", a_empty, 1);
    send_a(-1000);
    step;
    chk("lat e1", a_empty, 1);
    send_a(0);
    step;
    a_in_valid = 0;
    chk("lat e2", a_empty, 0);
    repeat (3) pop_a("unity");
    chk("sat clean", a_sat, 0);
    // half gain floors negatives
    b_in_valid = 1;
    b_in_data = 3;
    qb.push_back(model(3, 512));
    step;
    b_in_data = -3;
    qb.push_back(model(-3, 512));
    step;
    b_in_valid = 0;
    repeat (2) pop_b("half");
    chk("half sat", b_sat, 0);
    // saturation and sticky flag
    send_a(40000);
    step;
    send_a(-40000);
    step;
    a_in_valid = 0;
    repeat (2) pop_a("clip");
    chk("sat set", a_sat, 1);
    send_a(5);
    step;
    a_in_valid = 0;
    pop_a("post clip");
    chk("sat sticky", a_sat, 1);
    // fill to credit limit, then overflow
    a_in_valid = 1;
    for (int i = 0; i < 40 && a_in_ready; i++) begin
      a_in_data = 100 + i;
      qa.push_back(model(100 + i, 1024));
      acc++;
      step;
    end
    a_in_valid = 0;
    chk("accepted", acc, 16);
    step;
    step;
    chk("full ready", a_in_ready, 0);
    chk("no ovf yet", a_overflow, 0);
    a_in_valid = 1;
    a_in_data = 12345;
    step;
    a_in_valid = 0;
    chk("ovf", a_overflow, 1);
    chk("head kept", a_out, qa[0]);
    step;
    chk("still full", a_in_ready, 0);
    pop_a("credit pop");
    chk("ready after pop", a_in_ready, 1);
    while (qa.size() > 0) pop_a("drain");
    chk("drained", a_empty, 1);
    // push and pop on the same edge with one entry
    send_a(11);
    step;
    a_in_valid = 0;
    step;
    step;
    chk("one entry", a_out, qa[0]);
    send_a(22);
    step;
    a_in_valid = 0;
    step;
    a_rd = 1;
    step;
    a_rd = 0;
    void'(qa.pop_front());
    chk("pp nonempty", a_empty, 0);
    chk("pp head", a_out, qa[0]);
    a_rd = 1;
    step;
    a_rd = 0;
    void'(qa.pop_front());
    chk("pp count1", a_empty, 1);
    a_rd = 1;
    step;
    a_rd = 0;
    chk("underflow empty", a_empty, 1);
    chk("underflow ready", a_in_ready, 1);
    chk("underflow data", a_out, 0);
    // push into empty with rd held high
    a_rd = 1;
    send_a(44);
    step;
    a_in_valid = 0;
    step;
    step;
    chk("rd held kept", a_empty, 0);
    chk("rd held data", a_out, qa[0]);
    step;
    void'(qa.pop_front());
    a_rd = 0;
    chk("rd held popped", a_empty, 1);
    // reset with 5 queued and 2 in flight
    a_in_valid = 1;
    for (int i = 0; i < 7; i++) begin
      a_in_data = 200 + i;
      step;
    end
    a_in_valid = 0;
    chk("pre reset full", a_empty, 0);
    reset = 1;
    #1;
    chk_reset("mid reset");
    qa.delete();
    step;
    reset = 0;
    send_a(7);
    step;
    a_in_valid = 0;
    chk("post e0", a_empty, 1);
    step;
    chk("post e1", a_empty, 1);
    step;
    chk("post e2", a_empty, 0);
    pop_a("post reset");
    step;
    chk("post reset empty", a_empty, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
